// File: rtl/pipe_ctrl_sched.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_sched
// Purpose  : Central stall/flush scheduler for the 5-stage pipeline. Decodes
//            per-stage stall requests into per-register stall enables, turns
//            the MEM-stage exception code into flush + redirect PC, blanks
//            exceptions for a few cycles after each flush, and runs a sticky
//            stall watchdog.
// Options  : define PIPE_CTRL_PERF_EN to build the stall-cycle and flush
//            performance counters; otherwise both outputs are tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl_sched #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          BLANK_CYCLES  = 1,
  parameter int          STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [31:0]        ERET_CODE  = 32'h0000_000e;
  localparam int                 BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [15:0]        WD_MAX     = 16'(STALL_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t             state;
  logic [BLANK_W-1:0] blank_cnt;
  logic [15:0]        wd_cnt;
  logic [5:0]         stall_dec;
  logic               exc_accept;
  logic               stall_any;

  // Priority decode: a stalled stage freezes itself and every earlier stage.
  always_comb begin
    stall_dec = 6'b000000;
    if (stallreq_mem)     stall_dec = 6'b011111;
    else if (stallreq_ex) stall_dec = 6'b001111;
    else if (stallreq_id) stall_dec = 6'b000111;
    else if (stallreq_if) stall_dec = 6'b000011;
  end

  // Exceptions win over stalls; everything is forced quiet while in reset.
  always_comb begin
    exc_accept = !rst && (state == RUN) && (excepttype != 32'h0);
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0;
    if (exc_accept) begin
      flush  = 1'b1;
      new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
    end else if (!rst) begin
      stall = stall_dec;
    end
  end

  assign stall_any = (stall != 6'b000000);

  // Post-flush blanking: ignore the still-present exception code while the
  // flushed instructions drain out of MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      blank_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (exc_accept) begin
            state     <= BLANK;
            blank_cnt <= BLANK_LOAD;
          end
        end
        BLANK: begin
          if (blank_cnt == '0) state <= RUN;
          else                 blank_cnt <= blank_cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Watchdog: counts consecutive stalled cycles, flags a stuck pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt        <= 16'h0;
      stall_timeout <= 1'b0;
    end else begin
      if (flush || !stall_any)  wd_cnt <= 16'h0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 16'h1;
      if (stall_any && (wd_cnt == WD_MAX)) stall_timeout <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Free-running perf counters; both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 16'h0;
    end else begin
      if (stall_any) stall_cycles_q <= stall_cycles_q + 32'h1;
      if (flush)     flush_count_q  <= flush_count_q + 16'h1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 16'h0;
`endif

endmodule
`default_nettype wire
